// File: rtl/nibble_serial_adder.sv
// Serial adder for 4*NIBBLES-bit operands: one nibble per cycle through a single carry-select slice.
// Latency: out_valid rises NIBBLES edges after the input handshake.
// Backpressure: in_ready=0 while busy; the result is held in DONE until out_ready.

module csa (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] SUM,
  output logic       CARRY
);
  logic [4:0] s0, s1;

  // Both carry hypotheses are computed up front; Cin only picks one.
  assign s0 = {1'b0, A} + {1'b0, B};
  assign s1 = {1'b0, A} + {1'b0, B} + 5'd1;
  assign {CARRY, SUM} = Cin ? s1 : s0;
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_reg, b_reg, work, work_nxt;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [IW+1:0]   lo;
  logic            last;
  logic [3:0]      nib_a, nib_b, nib_sum;
  logic            nib_carry;

  assign lo    = {idx, 2'b00};
  assign last  = (idx == IW'(NIBBLES - 1));
  assign nib_a = 4'(a_reg >> lo);
  assign nib_b = 4'(b_reg >> lo);

  csa u_csa (
    .A     (nib_a),
    .B     (nib_b),
    .Cin   (carry),
    .SUM   (nib_sum),
    .CARRY (nib_carry)
  );

  // Shift/mask insert avoids a variable part-select whose index width depends on NIBBLES.
  always_comb begin
    work_nxt = (work & ~(W'(4'hF) << lo)) | (W'(nib_sum) << lo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= nib_carry;
          if (last) begin
            sum  <= work_nxt;
            cout <= nib_carry;
            idx  <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at NIBBLES=4 and NIBBLES=1 using a result queue.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // NIBBLES=4 instance
  logic        iv4, ir4, ov4, or4, cin4, cout4, busy4;
  logic [15:0] a4, b4, sum4;
  // NIBBLES=1 instance
  logic        iv1, ir1, ov1, or1, cin1, cout1, busy1;
  logic [3:0]  a1, b1, sum1;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .busy(busy4)
  );
  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;
  logic [16:0] exp4_q[$];
  logic [4:0]  exp1_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand set at a negedge; returns at the negedge after the accepting edge.
  task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    chk("in_ready_before_send4", ir4, 1);
    a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
    @(posedge clk);
    exp4_q.push_back({1'b0, a} + {1'b0, b} + 17'(c));
    @(negedge clk);
    iv4 = 1'b0;
    a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (!ov4 && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!ov4) chk("timeout_out_valid4", 0, 1);
  endtask

  task automatic recv4(input string tag);
    logic [16:0] e;
    if (exp4_q.size() == 0) begin
      chk("scoreboard_empty4", 0, 1);
    end else begin
      e = exp4_q.pop_front();
      chk(tag, {cout4, sum4}, e);
    end
  endtask

  task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                     input logic check_lat);
    int lat;
    or4 = 1'b1;
    send4(a, b, c);
    wait4(lat);
    if (check_lat) chk({tag, "_latency"}, lat, 4);
    recv4(tag);
  endtask

  task automatic op1(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c,
                     input logic check_lat);
    int lat;
    logic [4:0] e;
    or1 = 1'b1;
    @(negedge clk);
    chk("in_ready_before_send1", ir1, 1);
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
    @(posedge clk);
    exp1_q.push_back({1'b0, a} + {1'b0, b} + 5'(c));
    @(negedge clk);
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 10) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!ov1) chk("timeout_out_valid1", 0, 1);
    if (check_lat) chk({tag, "_latency"}, lat, 1);
    e = exp1_q.pop_front();
    chk(tag, {cout1, sum1}, e);
  endtask

  initial begin
    int lat;
    logic [16:0] held;
    logic        seen;
    rst_n = 1'b0;
    iv4 = 0; or4 = 1; a4 = 0; b4 = 0; cin4 = 0;
    iv1 = 0; or1 = 1; a1 = 0; b1 = 0; cin1 = 0;
    #12;
    chk("rst_sum",       sum4, 0);
    chk("rst_cout",      cout4, 0);
    chk("rst_out_valid", ov4, 0);
    chk("rst_in_ready",  ir4, 1);
    chk("rst_busy",      busy4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op4("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b1);
    chk("sum_5555", sum4, 16'h5555);
    op4("ripple_ffff_0_c1", 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    chk("ripple_cout", cout4, 1);
    op4("ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    chk("ffff_sum", sum4, 16'hFFFF);
    op4("8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0);
    chk("8000_cout", cout4, 1);

    // Reset mid-RUN: sum currently holds a nonzero completed result (0x0000 w/ cout=1 -> use prior)
    op4("pre_reset", 16'h1111, 16'h2222, 1'b0, 1'b0);
    send4(16'h1234, 16'h4321, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("mid_run_busy", busy4, 1);
    rst_n = 1'b0;
    #1;
    exp4_q.delete();
    chk("midrst_sum",       sum4, 0);
    chk("midrst_cout",      cout4, 0);
    chk("midrst_out_valid", ov4, 0);
    chk("midrst_in_ready",  ir4, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov4) seen = 1'b1;
    end
    chk("no_result_after_reset", seen, 0);

    // Backpressure: hold out_ready low for 5 cycles in DONE
    or4 = 1'b0;
    send4(16'hA5A5, 16'h0F0F, 1'b1);
    wait4(lat);
    held = {cout4, sum4};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a4 = 16'h7777; b4 = 16'h1111; iv4 = 1'b1; end
      else iv4 = 1'b0;
      chk("bp_out_valid", ov4, 1);
      chk("bp_in_ready", ir4, 0);
      chk("bp_stable", {cout4, sum4}, held);
      @(posedge clk); @(negedge clk);
    end
    iv4 = 1'b0;
    recv4("bp_result");
    or4 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_release_out_valid", ov4, 0);
    chk("bp_release_in_ready", ir4, 1);
    chk("bp_release_busy", busy4, 0);
    @(posedge clk); @(negedge clk);
    chk("bp_pulse_ignored", busy4, 0);

    op1("n1_f_1", 4'hF, 4'h1, 1'b0, 1'b1);
    chk("n1_sum", sum1, 0);
    chk("n1_cout", cout1, 1);

    for (int i = 0; i < 1000; i++)
      op4("rand4", 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 200; i++)
      op1("rand1", 4'($urandom), 4'($urandom), 1'($urandom), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
